// File: rtl/irq_reg_bank_pkg.sv
// irq_reg_bank_pkg: shared address map, ID value, mode encodings and the
// byte-strobe merge helper for the interrupt/output register bank.
package irq_reg_bank_pkg;

    localparam logic [31:0] ADDR_ID           = 32'h0000_0000;
    localparam logic [31:0] ADDR_IRQ_ENABLE   = 32'h0000_0004;
    localparam logic [31:0] ADDR_IRQ_PENDING  = 32'h0000_0008;
    localparam logic [31:0] ADDR_IRQ_RAW      = 32'h0000_000C;
    localparam logic [31:0] ADDR_IRQ_MODE     = 32'h0000_0010;
    localparam logic [31:0] ADDR_IRQ_POLARITY = 32'h0000_0014;
    localparam logic [31:0] ADDR_TIMESTAMP    = 32'h0000_0018;
    localparam logic [31:0] ADDR_OUT_BASE     = 32'h0000_0040;

    localparam logic [31:0] ID_VALUE = 32'h5242_0002;

    localparam logic IRQ_MODE_LEVEL = 1'b0;
    localparam logic IRQ_MODE_EDGE  = 1'b1;

    // Replace only the strobed bytes of old_v with the matching bytes of new_v.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_channel_sync.sv
// irq_channel_sync: one interrupt channel front end. Two-flop synchroniser,
// polarity correction and rising-edge detect on the corrected level.
module irq_channel_sync
    import irq_reg_bank_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic irq_in,
    input  logic pol,
    output logic act,
    output logic irq_edge
);

    logic sync_p0;
    logic sync_p1;
    logic act_p2;

    // Synchroniser chain plus one delayed copy of the active level for edges.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            act_p2  <= 1'b0;
        end else begin
            sync_p0 <= irq_in;
            sync_p1 <= sync_p0;
            act_p2  <= act;
        end
    end

    // A polarity flip changes act directly, so it can raise one edge event.
    assign act      = sync_p1 ^ pol;
    assign irq_edge = act & ~act_p2;

endmodule

// File: rtl/irq_reg_bank.sv
// irq_reg_bank: generic byte-strobed output registers plus an NUM_IRQ-channel
// interrupt controller behind a simple write_en/read_en register port.
// Optional build macro IRQ_TIMESTAMP_EN adds a free-running cycle counter and
// a TIMESTAMP register that latches when irq_out rises.
module irq_reg_bank
    import irq_reg_bank_pkg::*;
#(
    parameter int          C_DATA_WIDTH  = 32,
    parameter int          C_ADDR_WIDTH  = 32,
    parameter int          NUM_IRQ       = 8,
    parameter int          NUM_OUT_REGS  = 4,
    parameter logic [31:0] OUT_RESET_VAL = 32'h0
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 write_en,
    input  logic [C_ADDR_WIDTH-1:0]              write_addr,
    input  logic [C_DATA_WIDTH-1:0]              write_data,
    input  logic [C_DATA_WIDTH/8-1:0]            write_strb,
    input  logic                                 read_en,
    input  logic [C_ADDR_WIDTH-1:0]              read_addr,
    output logic [C_DATA_WIDTH-1:0]              read_data,
    output logic                                 read_valid,
    output logic [NUM_OUT_REGS*C_DATA_WIDTH-1:0] out_regs,
    input  logic [NUM_IRQ-1:0]                   irq_in,
    output logic [NUM_IRQ-1:0]                   irq_vec,
    output logic                                 irq_out
);

    logic [NUM_IRQ-1:0] enable_q, mode_q, pol_q, pend_q;
    logic [NUM_IRQ-1:0] enable_d, mode_d, pol_d, pend_d;
    logic [NUM_IRQ-1:0] clr, set, act, irq_edge, wr_mask, vec_d;
    logic [31:0]        out_q [NUM_OUT_REGS];
    logic [31:0]        out_d [NUM_OUT_REGS];
    logic [C_ADDR_WIDTH-1:0] wr_word, rd_word;
    logic [31:0]        rd_mux;
    logic               unused_addr_lsbs;

    // Registers are word aligned; the byte offset bits carry no meaning.
    assign wr_word          = {write_addr[C_ADDR_WIDTH-1:2], 2'b00};
    assign rd_word          = {read_addr[C_ADDR_WIDTH-1:2], 2'b00};
    assign unused_addr_lsbs = ^{write_addr[1:0], read_addr[1:0]};

    genvar g;
    for (g = 0; g < NUM_IRQ; g++) begin : g_chan
        irq_channel_sync u_sync (
            .clk      (clk),
            .resetn   (resetn),
            .irq_in   (irq_in[g]),
            .pol      (pol_q[g]),
            .act      (act[g]),
            .irq_edge (irq_edge[g])
        );
        assign wr_mask[g] = write_strb[g/8];
    end

    for (g = 0; g < NUM_OUT_REGS; g++) begin : g_out
        assign out_regs[32*g +: 32] = out_q[g];
    end

`ifdef IRQ_TIMESTAMP_EN
    logic [31:0] cnt_q;
    logic [31:0] ts_q;

    // Free-running cycle counter; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_q + 32'd1;
    end

    // Capture the counter value seen in the first cycle irq_out is high.
    always_ff @(posedge clk) begin
        if (!resetn)                  ts_q <= '0;
        else if (|vec_d && !irq_out)  ts_q <= cnt_q + 32'd1;
    end
`endif

    // Register write decode with byte strobes; W1C builds the clear mask.
    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        pol_d    = pol_q;
        clr      = '0;
        for (int i = 0; i < NUM_OUT_REGS; i++) out_d[i] = out_q[i];
        if (write_en) begin
            if (wr_word == C_ADDR_WIDTH'(ADDR_IRQ_ENABLE))
                enable_d = (enable_q & ~wr_mask) | (write_data[NUM_IRQ-1:0] & wr_mask);
            if (wr_word == C_ADDR_WIDTH'(ADDR_IRQ_MODE))
                mode_d = (mode_q & ~wr_mask) | (write_data[NUM_IRQ-1:0] & wr_mask);
            if (wr_word == C_ADDR_WIDTH'(ADDR_IRQ_POLARITY))
                pol_d = (pol_q & ~wr_mask) | (write_data[NUM_IRQ-1:0] & wr_mask);
            if (wr_word == C_ADDR_WIDTH'(ADDR_IRQ_PENDING))
                clr = write_data[NUM_IRQ-1:0] & wr_mask;
            for (int i = 0; i < NUM_OUT_REGS; i++) begin
                if (wr_word == C_ADDR_WIDTH'(ADDR_OUT_BASE + 32'(4*i)))
                    out_d[i] = strb_merge(out_q[i], write_data, write_strb);
            end
        end
    end

    // Pending next state: a same-cycle set always beats a clear.
    always_comb begin
        set = '0;
        for (int i = 0; i < NUM_IRQ; i++)
            set[i] = (mode_q[i] == IRQ_MODE_EDGE) ? irq_edge[i] : act[i];
        pend_d = set | (pend_q & ~clr);
        vec_d  = pend_d & enable_d;
    end

    // Interrupt control state; outputs follow the next-state pending & enable.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            enable_q <= '0;
            mode_q   <= {NUM_IRQ{IRQ_MODE_LEVEL}};
            pol_q    <= '0;
            pend_q   <= '0;
            irq_vec  <= '0;
            irq_out  <= 1'b0;
        end else begin
            enable_q <= enable_d;
            mode_q   <= mode_d;
            pol_q    <= pol_d;
            pend_q   <= pend_d;
            irq_vec  <= vec_d;
            irq_out  <= |vec_d;
        end
    end

    // Generic output registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_OUT_REGS; i++) begin
            if (!resetn) out_q[i] <= OUT_RESET_VAL;
            else         out_q[i] <= out_d[i];
        end
    end

    // Read mux works on current state, so a same-cycle write is not visible.
    always_comb begin
        rd_mux = '0;
        if (rd_word == C_ADDR_WIDTH'(ADDR_ID))                rd_mux = ID_VALUE;
        else if (rd_word == C_ADDR_WIDTH'(ADDR_IRQ_ENABLE))   rd_mux[NUM_IRQ-1:0] = enable_q;
        else if (rd_word == C_ADDR_WIDTH'(ADDR_IRQ_PENDING))  rd_mux[NUM_IRQ-1:0] = pend_q;
        else if (rd_word == C_ADDR_WIDTH'(ADDR_IRQ_RAW))      rd_mux[NUM_IRQ-1:0] = act;
        else if (rd_word == C_ADDR_WIDTH'(ADDR_IRQ_MODE))     rd_mux[NUM_IRQ-1:0] = mode_q;
        else if (rd_word == C_ADDR_WIDTH'(ADDR_IRQ_POLARITY)) rd_mux[NUM_IRQ-1:0] = pol_q;
`ifdef IRQ_TIMESTAMP_EN
        else if (rd_word == C_ADDR_WIDTH'(ADDR_TIMESTAMP))    rd_mux = ts_q;
`endif
        for (int i = 0; i < NUM_OUT_REGS; i++) begin
            if (rd_word == C_ADDR_WIDTH'(ADDR_OUT_BASE + 32'(4*i))) rd_mux = out_q[i];
        end
    end

    // One-cycle read pipeline; data holds between reads.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= read_en;
            if (read_en) read_data <= rd_mux;
        end
    end

endmodule

// File: doc/irq_reg_bank.md
Name: irq_reg_bank

Overview:
- Parametrised successor to the single-interrupt LED/7-seg register bank.
- Sits behind the AXI4-Lite slave on the same write_en/read_en register interface.
- Provides NUM_OUT_REGS generic byte-strobed output registers and an NUM_IRQ-channel interrupt controller.
- Each channel has enable, edge/level mode, polarity, 2-flop synchroniser and W1C pending status.

Parameters:
- C_DATA_WIDTH, 32, register data width; only 32 is supported.
- C_ADDR_WIDTH, 32, address width; addr[1:0] are ignored.
- NUM_IRQ, 8, interrupt channels, legal range 1..32.
- NUM_OUT_REGS, 4, generic output registers, legal range 1..16.
- OUT_RESET_VAL, 32'h0, reset value of every output register.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- write_en  in  1  single-cycle write strobe
- write_addr  in  C_ADDR_WIDTH  write byte address
- write_data  in  C_DATA_WIDTH  write data
- write_strb  in  C_DATA_WIDTH/8  byte enables
- read_en  in  1  single-cycle read strobe
- read_addr  in  C_ADDR_WIDTH  read byte address
- read_data  out  C_DATA_WIDTH  registered read data
- read_valid  out  1  one-cycle pulse, read_data valid
- out_regs  out  NUM_OUT_REGS*C_DATA_WIDTH  flattened output registers; reg i at [32i+31:32i]
- irq_in  in  NUM_IRQ  asynchronous interrupt sources
- irq_vec  out  NUM_IRQ  pending & enable, registered
- irq_out  out  1  OR of irq_vec, registered

Behaviour:
- Address map (byte addresses):
  - 0x00 ID, RO, 32'h5242_0002
  - 0x04 IRQ_ENABLE, RW
  - 0x08 IRQ_PENDING, read / write-1-to-clear
  - 0x0C IRQ_RAW, RO, synchronised, polarity-corrected input levels
  - 0x10 IRQ_MODE, RW, 1 = edge, 0 = level
  - 0x14 IRQ_POLARITY, RW, 1 = active-low / falling edge
  - 0x18 TIMESTAMP, RO; reads 0 without the optional feature
  - 0x40+4*i OUT_REG[i], RW
- Per-channel registers use bits [NUM_IRQ-1:0]; upper bits read 0 and writes to them are ignored.
- Byte strobes apply to every RW and W1C register. Unstrobed bytes are unchanged or not cleared.
- Unmapped writes are ignored. Unmapped reads return 0 with read_valid still asserted.
- Reset values: all control, pending, enable, mode and polarity = 0; out_regs = OUT_RESET_VAL; read_data = 0; read_valid = 0; irq_vec = 0; irq_out = 0; synchroniser and edge flops = 0.
- Synchroniser:
  - 2-flop sync of irq_in, then XOR with polarity → act.
  - A third flop, act_d, is used for edge detection.
  - Edge event = act & ~act_d.
  - Input to pending latency is 3 cycles.
- Pending update, per bit, each cycle:
  - set = mode ? edge : act
  - clr = W1C write hitting that bit
  - pending <= set | (pending & ~clr)
  - Set wins over a same-cycle clear, so no event is lost.
  - In level mode a clear while the source is still active re-sets the bit the same cycle.
- Changing mode or polarity does not alter pending by itself. A polarity flip may produce one edge event, which is the accepted behaviour.
- irq_vec and irq_out are registered from the next-state pending & enable. Latency: pending visible in IRQ_PENDING and on irq_out in the same cycle.
- Read pipeline:
  - read_en in cycle N → read_data and read_valid=1 in cycle N+1.
  - read_valid drops in N+1 if read_en is low in N.
  - read_data holds when idle.
  - Back-to-back reads are supported at one per cycle.
  - A read and a write in the same cycle: the read returns the pre-write value.
- Reset mid-operation clears everything next edge. A pending read is dropped with no read_valid.

Optional Feature:
- Macro IRQ_TIMESTAMP_EN.
- When defined:
  - A 32-bit free-running cycle counter runs, wrapping at 0xFFFF_FFFF→0.
  - TIMESTAMP latches the counter value on the cycle irq_out goes 0→1.
  - It does not re-latch until irq_out returns to 0.
- When undefined: no counter is built and TIMESTAMP reads 0.

Decomposition:
- Package irq_reg_bank_pkg holds:
  - address offset localparams (ADDR_ID … ADDR_OUT_BASE)
  - ID_VALUE
  - IRQ_MODE_LEVEL/IRQ_MODE_EDGE encodings
  - the strobe-merge function (old, new, strb)
- Sub-module irq_channel_sync: one per channel via generate. Contains the 2-flop sync, polarity XOR and edge detect; outputs act and edge.

Test Plan:
- Reset, then read 0x00, 0x04 and 0x40 → 32'h5242_0002, 0, OUT_RESET_VAL; each read_valid is a single-cycle pulse one cycle after read_en.
- Write 0x40 data 0xAABBCCDD strb 4'b0101 starting from 0 → out_regs[31:0] = 0x00BB00DD; read back the same; write to 0x3C is ignored and reads 0.
- Edge channel 2: enable=0x04, mode=0x04, pulse irq_in[2] one cycle → pending=0x04 and irq_out=1 three cycles later; W1C 0x04 → pending 0, irq_out 0 next cycle.
- Level channel 0 with polarity=1: hold irq_in[0]=0 → pending bit0 set; W1C while still low → bit remains 1; release and W1C → bit clears.
- An edge on channel 1 coinciding with a W1C of bit 1 → pending bit1 stays 1.
- With IRQ_TIMESTAMP_EN: irq_out rises at counter value T → TIMESTAMP reads T; a second interrupt while irq_out is high leaves TIMESTAMP unchanged.
